// File: rtl/audio_min_max.sv
// audio_min_max: scans N DW-bit samples one per clock and reports min/max with start/done handshake.
// FLOAT_CMP_EN selects IEEE-754 single ordering with NaN skipping; otherwise signed integer compare.
module audio_min_max #(
  parameter int N  = 100,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [N*DW-1:0] raw_audio,
  output logic            d,
  output logic [DW-1:0]   out_max,
  output logic [DW-1:0]   out_min
);
  localparam int IW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx, sel;
  logic [DW-1:0] cur_min, cur_max, sample;
  logic cur_valid, is_nan, lt_min, gt_max, last;
  // Maps a sample to an unsigned key whose natural order is the sample order.
  function automatic logic [DW-1:0] key(input logic [DW-1:0] x);
`ifdef FLOAT_CMP_EN
    return (x[DW-2:0] == '0) ? {1'b1, {(DW-1){1'b0}}} : x[DW-1] ? ~x : {1'b1, x[DW-2:0]};
`else
    return {~x[DW-1], x[DW-2:0]};
`endif
  endfunction
  // idx reaches N once every sample is consumed; that extra cycle publishes the result.
  assign last   = idx == IW'(N);
  assign sel    = (state == SCAN && !last) ? idx : '0;
  assign sample = raw_audio[sel*DW +: DW];
`ifdef FLOAT_CMP_EN
  assign is_nan = sample[30:23] == 8'hFF && sample[22:0] != '0;
`else
  assign is_nan = 1'b0;
`endif
  assign lt_min = key(sample) < key(cur_min);
  assign gt_max = key(sample) > key(cur_max);
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == SCAN) ? (last ? DONE : SCAN) : (start ? SCAN : state);
  always_comb
    d = state == DONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      cur_min   <= '0;
      cur_max   <= '0;
      cur_valid <= 1'b0;
      out_min   <= '0;
      out_max   <= '0;
    end else if (state != SCAN && start) begin
      cur_min   <= sample;
      cur_max   <= sample;
      cur_valid <= !is_nan;
      idx       <= IW'(1);
    end else if (state == SCAN && !last) begin
      idx <= idx + 1'b1;
      if (!is_nan) begin
        if (!cur_valid || lt_min) cur_min <= sample;
        if (!cur_valid || gt_max) cur_max <= sample;
        cur_valid <= 1'b1;
      end
    end else if (state == SCAN) begin
`ifdef FLOAT_CMP_EN
      out_min <= cur_valid ? cur_min : DW'(32'h7FC00000);
      out_max <= cur_valid ? cur_max : DW'(32'h7FC00000);
`else
      out_min <= cur_min;
      out_max <= cur_max;
`endif
    end
  end
endmodule

// File: tb/tb_audio_min_max.sv
// tb_audio_min_max: randomized self-checking bench for audio_min_max against a signed min/max model.
module tb_audio_min_max;
  localparam int N  = 100;
  localparam int DW = 32;
  logic            clk = 0;
  logic            reset = 1;
  logic            start = 0;
  logic [N*DW-1:0] raw_audio = '0;
  logic            d;
  logic [DW-1:0]   out_max, out_min;
  logic [31:0]     samp [N];
  logic [31:0]     prev_lo = 0, prev_hi = 0, lo, hi;
  int n_chk = 0, n_pass = 0;

  audio_min_max #(.N(N), .DW(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .raw_audio(raw_audio),
    .d(d), .out_max(out_max), .out_min(out_min)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic load();
    for (int i = 0; i < N; i++) raw_audio[i*DW +: DW] = samp[i];
  endtask

  task automatic model(output logic [31:0] mn, output logic [31:0] mx);
    mn = samp[0];
    mx = samp[0];
    for (int i = 1; i < N; i++) begin
      if ($signed(samp[i]) < $signed(mn)) mn = samp[i];
      if ($signed(samp[i]) > $signed(mx)) mx = samp[i];
    end
  endtask

  task automatic scan(input string tag, input int restart_at, input logic [31:0] elo, input logic [31:0] ehi);
    int cyc;
    load();
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    check({tag, "_d_clear"}, {31'b0, d}, 0);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      start = (cyc == restart_at);
      if (cyc == 50) begin
        check({tag, "_hold_min"}, out_min, prev_lo);
        check({tag, "_hold_max"}, out_max, prev_hi);
      end
    end while (!d && cyc < N + 40);
    start = 0;
    check({tag, "_latency"}, cyc, N);
    check({tag, "_min"}, out_min, elo);
    check({tag, "_max"}, out_max, ehi);
    prev_lo = elo;
    prev_hi = ehi;
  endtask

  task automatic int_scan(input string tag, input int restart_at);
    model(lo, hi);
    scan(tag, restart_at, lo, hi);
  endtask

  initial begin
    for (int i = 0; i < N; i++) samp[i] = 0;
    repeat (5) @(posedge clk);
    #1;
    reset = 0;
    check("rst_d", {31'b0, d}, 0);
    check("rst_min", out_min, 0);
    check("rst_max", out_max, 0);
`ifndef FLOAT_CMP_EN
    for (int i = 0; i < N; i++) samp[i] = i - 50;
    int_scan("ramp", -1);
    check("ramp_min_const", out_min, 32'hFFFFFFCE);
    check("ramp_max_const", out_max, 32'h00000031);
    for (int i = 0; i < N; i++) samp[i] = 32'h12345678;
    int_scan("flat1", -1);
    int_scan("flat2", -1);
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) samp[i] = $urandom;
      if (r >= 3) begin
        samp[$urandom_range(N-1, 0)] = 32'h80000000;
        samp[$urandom_range(N-1, 0)] = 32'h7FFFFFFF;
      end
      int_scan("rand", -1);
    end
    for (int i = 0; i < N; i++) samp[i] = $urandom_range(200, 0) - 100;
    samp[N-1] = 32'h80000001;
    samp[0]   = 32'h7FFFFFFE;
    int_scan("edges", -1);
    for (int i = 0; i < N; i++) samp[i] = $urandom;
    load();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (39) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("abort_d", {31'b0, d}, 0);
    check("abort_min", out_min, 0);
    check("abort_max", out_max, 0);
    prev_lo = 0;
    prev_hi = 0;
    int_scan("after_abort", -1);
    for (int i = 0; i < N; i++) samp[i] = $urandom;
    int_scan("restart30", 30);
`else
    samp[0] = 32'h3F800000;
    samp[1] = 32'hC0000000;
    samp[2] = 32'h7FC00000;
    samp[3] = 32'h80000000;
    scan("fmix", -1, 32'hC0000000, 32'h3F800000);
    for (int i = 0; i < N; i++) samp[i] = (i % 2) ? 32'h7FC00000 : 32'hFF800001;
    scan("fnan", -1, 32'h7FC00000, 32'h7FC00000);
    for (int i = 0; i < N; i++) samp[i] = 32'h3F800000;
    samp[0] = 32'h7FC00000;
    samp[5] = 32'hBF800000;
    scan("fseed", -1, 32'hBF800000, 32'h3F800000);
    for (int i = 0; i < N; i++) samp[i] = 0;
    samp[0] = 32'h80000000;
    scan("fzero", 30, 32'h80000000, 32'h80000000);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
